// File: rtl/view_ray_sched.sv
// -----------------------------------------------------------------------------
// view_ray_sched
//
// Frame-level sequencer for the view_ray datapath. A start pulse latches the
// camera normal and view distance, which then stay fixed for the whole frame.
// The block sweeps ray_loc over every screen cell in raster order (x fastest).
// It waits RAY_LAT cycles per cell for view_ray to settle, captures ray_out and
// presents each (location, direction) result downstream on a valid/ready
// handshake.
//
// Optional feature macro: RAY_SCHED_ABORT_EN
//   When defined, an extra input port "abort" is added. abort=1 in SETTLE or
//   EMIT returns the block to IDLE on the next edge. No frame_done is produced
//   and any presented result is dropped. The latched normal, distance and
//   location are kept.
//
// Ports:
//   clk             system clock, all state on the rising edge
//   rst             asynchronous active-low reset
//   start           one-cycle frame request, sampled only in IDLE
//   abort           (RAY_SCHED_ABORT_EN only) abandon the current frame
//   view_normal_in  camera normal, latched on an accepted start
//   view_dist_in    view distance, latched on an accepted start
//   ray_normal      latched normal driven to view_ray
//   ray_dist        latched distance driven to view_ray
//   ray_loc         current cell {x[6:0], y[5:0]} driven to view_ray
//   ray_out         view_ray result for ray_loc
//   out_valid       result available
//   out_ready       downstream accepts the result
//   out_loc         location of the presented result
//   out_dir         captured ray_out for out_loc
//   busy            high in every state except IDLE
//   frame_done      one-cycle pulse after the last cell is accepted
// -----------------------------------------------------------------------------
module view_ray_sched #(
    parameter int COLS    = 80,
    parameter int ROWS    = 60,
    parameter int RAY_LAT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef RAY_SCHED_ABORT_EN
    input  logic        abort,
`endif
    input  logic [30:0] view_normal_in,
    input  logic [7:0]  view_dist_in,
    output logic [30:0] ray_normal,
    output logic [7:0]  ray_dist,
    output logic [12:0] ray_loc,
    input  logic [30:0] ray_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [12:0] out_loc,
    output logic [30:0] out_dir,
    output logic        busy,
    output logic        frame_done
);

    localparam int CNT_W = (RAY_LAT > 1) ? $clog2(RAY_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAY_LAT - 1);
    localparam logic [6:0]       X_LAST   = 7'(COLS - 1);
    localparam logic [5:0]       Y_LAST   = 6'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EMIT   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [6:0]       x_r;
    logic [5:0]       y_r;
    logic [30:0]      ray_normal_r;
    logic [7:0]       ray_dist_r;
    logic [12:0]      out_loc_r;
    logic [30:0]      out_dir_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             frame_done_r;

    logic             abort_s;
    logic             hs_s;
    logic             last_cell_s;
    logic             load_s;
    logic             capture_s;
    logic             cnt_inc_s;
    logic             step_s;
    logic             finish_s;
    logic             drop_s;

`ifdef RAY_SCHED_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    assign hs_s        = out_valid_r & out_ready;
    assign last_cell_s = (x_r == X_LAST) && (y_r == Y_LAST);

    // Next-state decode and per-cycle control strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        capture_s   = 1'b0;
        cnt_inc_s   = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_EMIT;
                end else begin
                    cnt_inc_s   = 1'b1;
                end
            end
            ST_EMIT: begin
                // Abort wins over a simultaneous handshake: the result is dropped.
                if (abort_s) begin
                    drop_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (hs_s) begin
                    drop_s = 1'b1;
                    if (last_cell_s) begin
                        finish_s    = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        step_s      = 1'b1;
                        state_nxt_s = ST_SETTLE;
                    end
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Frame parameters: change only on an accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ray_normal_r <= 31'd0;
            ray_dist_r   <= 8'd0;
        end else if (load_s) begin
            ray_normal_r <= view_normal_in;
            ray_dist_r   <= view_dist_in;
        end
    end

    // Raster position: cleared on start, advanced only on a non-final handshake,
    // so it keeps the last cell after the frame ends or is aborted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r <= 7'd0;
            y_r <= 6'd0;
        end else if (load_s) begin
            x_r <= 7'd0;
            y_r <= 6'd0;
        end else if (step_s) begin
            if (x_r == X_LAST) begin
                x_r <= 7'd0;
                y_r <= y_r + 6'd1;
            end else begin
                x_r <= x_r + 7'd1;
            end
        end
    end

    // Settle counter: counts SETTLE cycles since ray_loc last became stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (load_s || step_s || finish_s) begin
            cnt_r <= '0;
        end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Result capture and valid flag; location and direction hold while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_loc_r   <= 13'd0;
            out_dir_r   <= 31'd0;
            out_valid_r <= 1'b0;
        end else if (capture_s) begin
            out_loc_r   <= {x_r, y_r};
            out_dir_r   <= ray_out;
            out_valid_r <= 1'b1;
        end else if (drop_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Status flags, registered from the next state so busy falls with frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            busy_r       <= (state_nxt_s != ST_IDLE);
            frame_done_r <= finish_s;
        end
    end

    assign ray_normal = ray_normal_r;
    assign ray_dist   = ray_dist_r;
    assign ray_loc    = {x_r, y_r};
    assign out_valid  = out_valid_r;
    assign out_loc    = out_loc_r;
    assign out_dir    = out_dir_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_view_ray_sched.sv
// -----------------------------------------------------------------------------
// tb_view_ray_sched
//
// Directed bench for view_ray_sched with COLS=4, ROWS=2, RAY_LAT=3. view_ray
// is stubbed as ray_out = {18'b0, ray_loc}. Each frame pushes its expected cell
// sequence into a queue. A negedge monitor pops and compares on every accepted
// result. When RAY_SCHED_ABORT_EN is defined, the abort port is also exercised.
// -----------------------------------------------------------------------------
module tb_view_ray_sched;

    localparam int COLS    = 4;
    localparam int ROWS    = 2;
    localparam int RAY_LAT = 3;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort_v;
    logic [30:0] view_normal_in;
    logic [7:0]  view_dist_in;
    logic [30:0] ray_normal;
    logic [7:0]  ray_dist;
    logic [12:0] ray_loc;
    logic [30:0] ray_out;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] out_loc;
    logic [30:0] out_dir;
    logic        busy;
    logic        frame_done;

    int          n_pass;
    int          n_total;
    int          n_pop;
    int          done_cnt;
    logic [12:0] exp_loc_q[$];
    logic [12:0] mon_e;

    localparam logic [30:0] N1 = 31'b00000000000_00000000001_000000000;
    localparam logic [30:0] N2 = 31'b00000000000_00000000111_000000101;

    assign ray_out = {18'd0, ray_loc};

    view_ray_sched #(.COLS(COLS), .ROWS(ROWS), .RAY_LAT(RAY_LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
`ifdef RAY_SCHED_ABORT_EN
        .abort          (abort_v),
`endif
        .view_normal_in (view_normal_in),
        .view_dist_in   (view_dist_in),
        .ray_normal     (ray_normal),
        .ray_dist       (ray_dist),
        .ray_loc        (ray_loc),
        .ray_out        (ray_out),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_loc        (out_loc),
        .out_dir        (out_dir),
        .busy           (busy),
        .frame_done     (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every accepted result against the queue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready && !abort_v) begin
            if (exp_loc_q.size() == 0) begin
                check("sb_unexpected_result", 64'(out_loc), 64'h1fff_ffff);
            end else begin
                mon_e = exp_loc_q.pop_front();
                check("sb_out_loc", 64'(out_loc), 64'(mon_e));
                check("sb_out_dir", 64'(out_dir), 64'({18'd0, mon_e}));
            end
            n_pop++;
        end
        if (frame_done) begin
            done_cnt++;
        end
    end

    task automatic push_frame();
        for (int y = 0; y < ROWS; y++) begin
            for (int x = 0; x < COLS; x++) begin
                exp_loc_q.push_back({7'(x), 6'(y)});
            end
        end
    endtask

    // Pulse start for one edge (edge 0); returns #1 after that edge.
    task automatic start_frame(input logic [30:0] nrm, input logic [7:0] dst);
        @(negedge clk);
        start          = 1'b1;
        view_normal_in = nrm;
        view_dist_in   = dst;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_valid_timeout", 64'(out_valid), 64'(1));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!frame_done && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("wait_done_timeout", 64'(frame_done), 64'(1));
    endtask

    task automatic wait_pops(input int target);
        int g;
        g = 0;
        while (n_pop < target && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("wait_pops_timeout", 64'(n_pop >= target), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          d0;
        int          p0;
        logic        bad;
        logic [12:0] hold_loc;
        logic [30:0] hold_dir;
        logic [12:0] hold_ray;

        n_pass = 0; n_total = 0; n_pop = 0; done_cnt = 0;
        rst = 1'b0; start = 1'b0; abort_v = 1'b0; out_ready = 1'b0;
        view_normal_in = 31'd0; view_dist_in = 8'd0;

        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_zero", 64'(|{ray_normal, ray_dist, ray_loc, out_loc, out_dir,
                                       out_valid, busy, frame_done}), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (|{ray_normal, ray_dist, ray_loc, out_loc, out_dir, out_valid, busy, frame_done})
                bad = 1'b1;
        end
        check("idle_quiet_20", 64'(bad), 64'(0));

        // Basic frame, ready tied high
        out_ready = 1'b1;
        push_frame();
        d0 = done_cnt; p0 = n_pop;
        start_frame(N1, 8'd3);
        check("basic_ray_normal", 64'(ray_normal), 64'(N1));
        check("basic_ray_dist", 64'(ray_dist), 64'(8'd3));
        check("basic_busy", 64'(busy), 64'(1));
        wait_valid(n);
        check("basic_first_valid_edge", 64'(n), 64'(3));
        check("basic_first_loc", 64'(out_loc), 64'(0));
        wait_done(n);
        // last valid at edge 31, handshake at edge 32; counted from edge 3
        check("basic_done_edge", 64'(n), 64'(29));
        check("basic_busy_low_at_done", 64'(busy), 64'(0));
        check("basic_last_ray_loc", 64'(ray_loc), 64'({7'd3, 6'd1}));
        @(posedge clk);
        #1;
        check("basic_done_one_cycle", 64'(frame_done), 64'(0));
        check("basic_done_count", 64'(done_cnt - d0), 64'(1));
        check("basic_result_count", 64'(n_pop - p0), 64'(8));

        // Backpressure on the 2nd result
        push_frame();
        d0 = done_cnt; p0 = n_pop;
        start_frame(N1, 8'd3);
        wait_valid(n);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        wait_valid(n);
        check("stall_loc", 64'(out_loc), 64'({7'd1, 6'd0}));
        hold_loc = out_loc; hold_dir = out_dir; hold_ray = ray_loc;
        bad = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || out_loc !== hold_loc || out_dir !== hold_dir || ray_loc !== hold_ray)
                bad = 1'b1;
        end
        check("stall_stable", 64'(bad), 64'(0));
        check("stall_ray_loc", 64'(ray_loc), 64'({7'd1, 6'd0}));
        out_ready = 1'b1;
        wait_done(n);
        @(posedge clk);
        #1;
        check("stall_done_count", 64'(done_cnt - d0), 64'(1));
        check("stall_result_count", 64'(n_pop - p0), 64'(8));

        // Start ignored while busy
        push_frame();
        d0 = done_cnt; p0 = n_pop;
        start_frame(N1, 8'd3);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b1; view_normal_in = N2; view_dist_in = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_start_normal", 64'(ray_normal), 64'(N1));
        check("busy_start_dist", 64'(ray_dist), 64'(8'd3));
        wait_done(n);
        repeat (3) @(posedge clk);
        #1;
        check("busy_start_done_count", 64'(done_cnt - d0), 64'(1));
        check("busy_start_result_count", 64'(n_pop - p0), 64'(8));
        check("busy_start_idle", 64'(busy), 64'(0));

        // Reset mid-frame during EMIT of the 5th result
        for (int i = 0; i < 4; i++) exp_loc_q.push_back({7'(i), 6'd0});
        d0 = done_cnt; p0 = n_pop;
        start_frame(N2, 8'd7);
        wait_pops(p0 + 4);
        out_ready = 1'b0;
        wait_valid(n);
        check("rst_mid_5th_loc", 64'(out_loc), 64'({7'd0, 6'd1}));
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", 64'(out_valid), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_ray_loc", 64'(ray_loc), 64'(0));
        check("rst_mid_normal", 64'(ray_normal), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        check("rst_mid_queue_empty", 64'(exp_loc_q.size()), 64'(0));
        out_ready = 1'b1;
        push_frame();
        start_frame(N1, 8'd5);
        check("rst_restart_loc", 64'(ray_loc), 64'(0));
        wait_done(n);
        @(posedge clk);
        #1;
        check("rst_done_count", 64'(done_cnt - d0), 64'(1));
        check("rst_result_count", 64'(n_pop - p0), 64'(12));

`ifdef RAY_SCHED_ABORT_EN
        // Abort together with a handshake on the 3rd result
        for (int i = 0; i < 2; i++) exp_loc_q.push_back({7'(i), 6'd0});
        d0 = done_cnt; p0 = n_pop;
        start_frame(N2, 8'd4);
        wait_pops(p0 + 2);
        wait_valid(n);
        check("abort_3rd_loc", 64'(out_loc), 64'({7'd2, 6'd0}));
        abort_v = 1'b1;
        @(posedge clk);
        #1;
        abort_v = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_valid", 64'(out_valid), 64'(0));
        check("abort_ray_loc_kept", 64'(ray_loc), 64'({7'd2, 6'd0}));
        check("abort_normal_kept", 64'(ray_normal), 64'(N2));
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cnt - d0), 64'(0));
        check("abort_pops", 64'(n_pop - p0), 64'(2));
        push_frame();
        start_frame(N1, 8'd3);
        check("abort_restart_loc", 64'(ray_loc), 64'(0));
        wait_done(n);
        @(posedge clk);
        #1;
        check("abort_restart_done", 64'(done_cnt - d0), 64'(1));
`endif

        check("final_queue_empty", 64'(exp_loc_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
